// File: rtl/lamp_controller.sv
// Lamp mode/state controller: button short/long press decoder plus manual/auto FSM.
// Optional input synchronizers are enabled with `define LAMP_INPUT_SYNC_EN.
module lamp_controller #(
  parameter int unsigned DEBOUNCE_T   = 100,
  parameter int unsigned LONG_PRESS_T = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  input  logic C,
  output logic L,
  output logic enable
);

  localparam logic [15:0] DebounceT = 16'(DEBOUNCE_T);
  localparam logic [15:0] LongT     = 16'(LONG_PRESS_T);

  typedef enum logic [1:0] {
    ManualOff = 2'd0,
    ManualOn  = 2'd1,
    AutoOff   = 2'd2,
    AutoOn    = 2'd3
  } state_e;

  logic btn;
  logic ir;

`ifdef LAMP_INPUT_SYNC_EN
  logic [1:0] btn_sync_q;
  logic [1:0] ir_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync_q <= 2'b00;
      ir_sync_q  <= 2'b00;
    end else begin
      btn_sync_q <= {btn_sync_q[0], push_button};
      ir_sync_q  <= {ir_sync_q[0], infravermelho};
    end
  end

  assign btn = btn_sync_q[1];
  assign ir  = ir_sync_q[1];
`else
  assign btn = push_button;
  assign ir  = infravermelho;
`endif

  logic [15:0] tp_q, tp_d;
  logic        long_evt, long_d;
  logic        short_evt, short_d;

  // Saturation at LongT means the long event can fire only once per hold.
  always_comb begin
    tp_d    = tp_q;
    long_d  = 1'b0;
    short_d = 1'b0;
    if (btn) begin
      if (tp_q != LongT) begin
        tp_d   = tp_q + 16'd1;
        long_d = (tp_d == LongT);
      end
    end else begin
      tp_d    = 16'd0;
      short_d = (tp_q >= DebounceT) && (tp_q < LongT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q      <= 16'd0;
      long_evt  <= 1'b0;
      short_evt <= 1'b0;
    end else begin
      tp_q      <= tp_d;
      long_evt  <= long_d;
      short_evt <= short_d;
    end
  end

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ManualOff: begin
        if (long_evt)       state_d = AutoOff;
        else if (short_evt) state_d = ManualOn;
      end
      ManualOn: begin
        if (long_evt)       state_d = AutoOff;
        else if (short_evt) state_d = ManualOff;
      end
      AutoOff: begin
        if (long_evt)       state_d = ManualOff;
        else if (short_evt) state_d = AutoOn;
        else if (ir)        state_d = AutoOn;
      end
      AutoOn: begin
        // Presence masks the timer's shutdown pulse.
        if (long_evt)       state_d = ManualOff;
        else if (short_evt) state_d = AutoOff;
        else if (C && !ir)  state_d = AutoOff;
      end
      default: state_d = ManualOff;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ManualOff;
    end else begin
      state_q <= state_d;
    end
  end

  assign L      = (state_q == ManualOn) || (state_q == AutoOn);
  assign enable = (state_q == AutoOn);

endmodule

// File: doc/lamp_controller.md
# lamp_controller

Mode and lamp state machine for the automatic lighting system. It decodes a raw push button into short-press and long-press events, and drives the lamp output `L` in manual or automatic mode. It is the consumer of the auto-shutdown timer handshake: it asserts `enable` toward the timer while the lamp is on in automatic mode, and turns the lamp off on the timer's one-cycle `C` pulse.

## Interface
- `DEBOUNCE_T`, default 100: minimum cycles the button must be held for a press to count.
- `LONG_PRESS_T`, default 3000: held cycles at which a press becomes a long press. Constraint: DEBOUNCE_T < LONG_PRESS_T ≤ 65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `push_button`  in  1  raw button, high = pressed.
- `infravermelho`  in  1  presence sensor, high = presence.
- `C`  in  1  auto-shutdown pulse from the timer, one cycle wide.
- `L`  out  1  lamp on.
- `enable`  out  1  timer enable; high only in state AUTO_ON.

## Operation
- **Button decoder.**
  - 16-bit hold counter `Tp` increments each cycle the button is sampled high, and saturates at LONG_PRESS_T.
  - Sample `Tp+1 == LONG_PRESS_T` while held: emit registered `long_evt` for exactly one cycle. No further events until the button is released.
  - Sample button low with DEBOUNCE_T ≤ Tp < LONG_PRESS_T: emit registered `short_evt` for one cycle.
  - Release with Tp < DEBOUNCE_T: glitch, no event.
  - Release in any case clears `Tp` to 0.
  - `short_evt` and `long_evt` are mutually exclusive by construction.
- **Mode FSM states:** MANUAL_OFF, MANUAL_ON, AUTO_OFF, AUTO_ON. Any other encoding goes to MANUAL_OFF.
  - **MANUAL_OFF:** long → AUTO_OFF; short → MANUAL_ON.
  - **MANUAL_ON:** long → AUTO_OFF; short → MANUAL_OFF.
  - **AUTO_OFF:** priority long > short > ir. long → MANUAL_OFF; short → AUTO_ON (manual switch-on, timer still applies); `infravermelho` → AUTO_ON.
  - **AUTO_ON:** priority long > short > C. long → MANUAL_OFF; short → AUTO_OFF; `C && !infravermelho` → AUTO_OFF. If `C` and `infravermelho` are both high in the same cycle, presence wins and the state stays AUTO_ON.
  - In every other state `C` is ignored.
- **Outputs (Moore, decoded from the registered state):**
  - `L` = (MANUAL_ON | AUTO_ON).
  - `enable` = AUTO_ON.

## Timing
- **Reset:** state MANUAL_OFF, `Tp` = 0, events = 0, `L` = 0, `enable` = 0, synchronizer flops = 0.
- **Short press latency:** edge k samples the release; `short_evt` is high during cycle k→k+1; state updates at edge k+1. `L` changes after edge k+1, i.e. 2 edges after the release is sampled.
- **Long press latency:** the state changes at the edge after the one where `Tp` reaches LONG_PRESS_T. This is the (LONG_PRESS_T+1)th edge of the hold.
- **Timer path:** `C` sampled at edge k in AUTO_ON gives `L` = 0 and `enable` = 0 after edge k. `infravermelho` sampled high at edge k in AUTO_OFF gives `L` = 1 and `enable` = 1 after edge k.
- **Timer restart:** after an AUTO_ON → AUTO_OFF → AUTO_ON sequence, `enable` drops for at least one cycle, so the timer restarts from zero.
- **Reset mid-press:** if the button is still held after `rst` deasserts, counting starts from `Tp` = 0 and the hold is treated as a new press.
- **Reset mid-AUTO_ON:** the block returns to MANUAL_OFF. `enable` falls asynchronously.

## Configuration
- **`LAMP_INPUT_SYNC_EN` defined:** `push_button` and `infravermelho` each pass through a two-flop synchronizer before use. All input-to-output latencies grow by 2 cycles. `C` is not synchronized, because it comes from the same clock domain.
- **Not defined:** raw inputs feed the decoder and FSM directly. Latencies are as stated in Timing.

## Test plan
Bench uses DEBOUNCE_T=4 and LONG_PRESS_T=10, with the macro undefined.
1. **Reset:** assert `rst` mid-cycle with the button held → `L`=0 and `enable`=0 immediately. Release `rst` and hold the button 3 more cycles → no event, `L` stays 0.
2. **Short press:** hold the button 6 cycles then release → `L`=1 exactly 2 edges after the release is sampled. Repeat → `L`=0.
3. **Long press:** hold 20 cycles → state AUTO_OFF, with exactly one `long_evt` and no `short_evt` on release. Then set `infravermelho`=1 → `L`=1 and `enable`=1 after the next edge.
4. **Timer handshake:** in AUTO_ON with `infravermelho`=0, pulse `C` for 1 cycle → `L`=0 and `enable`=0 after that edge. Pulse `C` in MANUAL_ON → `L` stays 1.
5. **Simultaneous events:** in AUTO_ON, drive `C`=1 together with `infravermelho`=1 → stays AUTO_ON. In AUTO_ON, a long press completing while `C`=1 → MANUAL_OFF.
6. **Sync build:** with `LAMP_INPUT_SYNC_EN` defined, repeat scenario 2 → `L` rises 4 edges after the raw release.
